// File: rtl/gc_gate_scheduler_if.sv
// gc_gate_scheduler_if: gate-descriptor input and garbled-result output handshakes of the gate scheduler.
interface gc_gate_scheduler_if #(parameter int S = 20, parameter int K = 128, parameter int AW = 16);
  logic          g_valid;
  logic          g_ready;
  logic [3:0]    g_logic;
  logic [K-1:0]  g_in0_label;
  logic [K-1:0]  g_in1_label;
  logic [AW-1:0] g_out_addr;
  logic          o_valid;
  logic          o_ready;
  logic [K-1:0]  o_t0;
  logic [K-1:0]  o_t1;
  logic [K-1:0]  o_label;
  logic [AW-1:0] o_addr;
  logic [S-1:0]  o_gid;
  modport master (
    output g_valid, g_logic, g_in0_label, g_in1_label, g_out_addr, o_ready,
    input  g_ready, o_valid, o_t0, o_t1, o_label, o_addr, o_gid
  );
  modport slave (
    input  g_valid, g_logic, g_in0_label, g_in1_label, g_out_addr, o_ready,
    output g_ready, o_valid, o_t0, o_t1, o_label, o_addr, o_gid
  );
endinterface

// File: rtl/gc_gate_scheduler.sv
// gc_gate_scheduler: credit-gated issue of AND gates into a fixed-latency garbling engine, results buffered in order.
// Defining GC_SCHED_STATS_EN adds the stall_cycles credit-stall counter output.
module gc_gate_scheduler #(
  parameter int S   = 20,
  parameter int K   = 128,
  parameter int AW  = 16,
  parameter int LAT = 10,
  parameter int D   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [S-1:0]  n_gates,
  output logic          busy,
  output logic          done,
  gc_gate_scheduler_if.slave bus,
  output logic [S-1:0]  eng_cid,
  output logic [S-1:0]  eng_gid,
  output logic [3:0]    eng_g_logic,
  output logic [K-1:0]  eng_in0_label,
  output logic [K-1:0]  eng_in1_label,
  input  logic [K-1:0]  eng_t0,
  input  logic [K-1:0]  eng_t1,
  input  logic [K-1:0]  eng_out_label,
  output logic [S-1:0]  cid
`ifdef GC_SCHED_STATS_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);
  localparam int IW = $clog2(LAT + 1);
  localparam int OW = $clog2(D + 1);
  localparam int PW = $clog2(D);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [K-1:0]  t0;
    logic [K-1:0]  t1;
    logic [K-1:0]  lbl;
    logic [AW-1:0] addr;
    logic [S-1:0]  gid;
  } ent_t;
  state_t        state, state_n;
  logic [S-1:0]  remaining, gid;
  logic [IW-1:0] inflight;
  logic [OW-1:0] occ, occ_n;
  logic [PW-1:0] wp, rp;
  logic [LAT-1:0] tv;
  logic [AW-1:0] ta [LAT];
  logic [S-1:0]  tg [LAT];
  ent_t          mem [D];
  logic [S-1:0]  l_cid, l_gid;
  logic [3:0]    l_logic;
  logic [K-1:0]  l_in0, l_in1;
  logic          credit, fire, wr, rd;
  // Credits count both buffered results and results still inside the engine, so an exiting tag always has a slot.
  assign credit = 32'(occ) + 32'(inflight) < D;
  assign bus.g_ready = state == RUN && remaining != '0 && credit;
  assign fire = bus.g_valid && bus.g_ready;
  assign wr = tv[LAT-1];
  assign rd = bus.o_valid && bus.o_ready;
  assign occ_n = occ + OW'(wr) - OW'(rd);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign eng_cid       = fire ? cid : l_cid;
  assign eng_gid       = fire ? gid : l_gid;
  assign eng_g_logic   = fire ? bus.g_logic : l_logic;
  assign eng_in0_label = fire ? bus.g_in0_label : l_in0;
  assign eng_in1_label = fire ? bus.g_in1_label : l_in1;
  assign bus.o_valid = occ != '0;
  assign bus.o_t0    = bus.o_valid ? mem[rp].t0 : '0;
  assign bus.o_t1    = bus.o_valid ? mem[rp].t1 : '0;
  assign bus.o_label = bus.o_valid ? mem[rp].lbl : '0;
  assign bus.o_addr  = bus.o_valid ? mem[rp].addr : '0;
  assign bus.o_gid   = bus.o_valid ? mem[rp].gid : '0;
  // Looking at the next occupancy lets done follow the final output handshake by one cycle.
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? RUN : IDLE) :
              state == RUN   ? (remaining == '0 ? DRAIN : RUN) :
              state == DRAIN ? ((inflight == '0 && occ_n == '0) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      gid       <= '0;
      cid       <= '0;
      inflight  <= '0;
      occ       <= '0;
      wp        <= '0;
      rp        <= '0;
      tv        <= '0;
      l_cid     <= '0;
      l_gid     <= '0;
      l_logic   <= '0;
      l_in0     <= '0;
      l_in1     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        remaining <= n_gates;
        gid       <= '0;
      end else if (fire) begin
        remaining <= remaining - 1'b1;
        gid       <= gid + 1'b1;
      end
      if (state == DONE) cid <= cid + 1'b1;
      if (fire) begin
        l_cid   <= cid;
        l_gid   <= gid;
        l_logic <= bus.g_logic;
        l_in0   <= bus.g_in0_label;
        l_in1   <= bus.g_in1_label;
      end
      tv       <= {tv[LAT-2:0], fire};
      inflight <= inflight + IW'(fire) - IW'(wr);
      occ      <= occ_n;
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    ta[0] <= bus.g_out_addr;
    tg[0] <= gid;
    for (int i = 1; i < LAT; i++) begin
      ta[i] <= ta[i-1];
      tg[i] <= tg[i-1];
    end
    if (wr) mem[wp] <= {eng_t0, eng_t1, eng_out_label, ta[LAT-1], tg[LAT-1]};
  end
`ifdef GC_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else if (state == IDLE && start) stall_cycles <= '0;
    else if (state == RUN && bus.g_valid && remaining != '0 && !credit && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif
  assert property (@(posedge clk) disable iff (rst) !(wr && occ == OW'(D)));
endmodule

// File: tb/tb_gc_gate_scheduler.sv
// tb_gc_gate_scheduler: randomized scoreboard bench with a behavioural engine model for gc_gate_scheduler.
module tb_gc_gate_scheduler;
  localparam int S = 20, K = 128, AW = 16, LAT = 10, D = 4;
  typedef struct {
    logic [AW-1:0] addr;
    logic [S-1:0]  gid;
    logic [K-1:0]  t0, t1, lbl;
  } exp_t;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [S-1:0] n_gates = '0, cid, eng_cid, eng_gid;
  logic [3:0] eng_g_logic;
  logic [K-1:0] eng_in0_label, eng_in1_label, eng_t0, eng_t1, eng_out_label;
`ifdef GC_SCHED_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] exp_stall = 0;
`endif
  gc_gate_scheduler_if #(.S(S), .K(K), .AW(AW)) bus();
  gc_gate_scheduler #(.S(S), .K(K), .AW(AW), .LAT(LAT), .D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .n_gates(n_gates), .busy(busy), .done(done),
    .bus(bus), .eng_cid(eng_cid), .eng_gid(eng_gid), .eng_g_logic(eng_g_logic),
    .eng_in0_label(eng_in0_label), .eng_in1_label(eng_in1_label),
    .eng_t0(eng_t0), .eng_t1(eng_t1), .eng_out_label(eng_out_label), .cid(cid)
`ifdef GC_SCHED_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  int total = 0, bad = 0, cyc = 0, t0c = 0, done_cyc = 0;
  int vpct = 0, rpct = 100, fires = 0, hs_cnt = 0, done_cnt = 0, rem_m = 0;
  logic [S-1:0] exp_cid = '0, exp_gid = '0;
  logic fired = 0;
  exp_t q[$];
  int fire_cyc[$], hs_cyc[$];
  logic [3*K-1:0] cur, pipe [LAT];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [3*K-1:0] eng_ref(logic [3:0] lg, logic [K-1:0] a, logic [K-1:0] b,
                                             logic [S-1:0] c, logic [S-1:0] g);
    logic [K-1:0] t0, t1, l;
    t0 = a ^ b;
    t1 = a + b + K'(lg);
    l  = {a[K/2-1:0], a[K-1:K/2]} ^ b ^ K'({c, g, lg});
    return {t0, t1, l};
  endfunction
  always @(negedge clk) cur <= eng_ref(eng_g_logic, eng_in0_label, eng_in1_label, eng_cid, eng_gid);
  always @(posedge clk) begin
    pipe[0] <= cur;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {eng_t0, eng_t1, eng_out_label} = pipe[LAT-1];
  task automatic chk(string name, logic [K-1:0] act, logic [K-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    if (!bus.g_valid || fired || vpct == 0) begin
      bus.g_valid     = ($urandom % 100) < vpct;
      bus.g_logic     = 4'($urandom);
      bus.g_in0_label = {$urandom, $urandom, $urandom, $urandom};
      bus.g_in1_label = {$urandom, $urandom, $urandom, $urandom};
      bus.g_out_addr  = AW'($urandom);
    end
    bus.o_ready = ($urandom % 100) < rpct;
  end
  always @(negedge clk) begin
    exp_t e;
    fired = 0;
`ifdef GC_SCHED_STATS_EN
    if (busy && rem_m != 0 && bus.g_valid && !bus.g_ready) exp_stall++;
`endif
    if (bus.g_valid && bus.g_ready) begin
      fired = 1;
      chk("eng_gid", K'(eng_gid), K'(exp_gid));
      chk("eng_cid", K'(eng_cid), K'(exp_cid));
      chk("eng_in0", eng_in0_label, bus.g_in0_label);
      e.addr = bus.g_out_addr;
      e.gid  = exp_gid;
      {e.t0, e.t1, e.lbl} = eng_ref(bus.g_logic, bus.g_in0_label, bus.g_in1_label, exp_cid, exp_gid);
      q.push_back(e);
      fire_cyc.push_back(cyc - t0c);
      fires++;
      exp_gid++;
      rem_m--;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_valid && bus.o_ready) begin
      hs_cnt++;
      hs_cyc.push_back(cyc - t0c);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got gid %0d want none", bus.o_gid);
      end else begin
        e = q.pop_front();
        chk("o_gid", K'(bus.o_gid), K'(e.gid));
        chk("o_addr", K'(bus.o_addr), K'(e.addr));
        chk("o_t0", bus.o_t0, e.t0);
        chk("o_t1", bus.o_t1, e.t1);
        chk("o_label", bus.o_label, e.lbl);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - t0c;
      exp_cid++;
      chk("done_drained", K'(q.size()), K'(0));
    end
  end
  task automatic do_start(int n);
    @(posedge clk);
    #1;
    start = 1;
    n_gates = S'(n);
    t0c = cyc;
    exp_gid = '0;
    rem_m = n;
`ifdef GC_SCHED_STATS_EN
    exp_stall = 0;
`endif
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic wait_done(int budget, string name);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_timeout: got no done want done within %0d cycles", name, budget);
    end
  endtask
  task automatic wait_fires(int target, int budget);
    int k = 0;
    while (fires < target && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int f0, h0, d0;
    bus.g_valid = 0;
    bus.o_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", K'(busy), 0);
    chk("rst_done", K'(done), 0);
    chk("rst_g_ready", K'(bus.g_ready), 0);
    chk("rst_o_valid", K'(bus.o_valid), 0);
    chk("rst_cid", K'(cid), 0);
    chk("rst_eng_gid", K'(eng_gid), 0);
    chk("rst_eng_in0", eng_in0_label, 0);
    chk("rst_o_label", bus.o_label, 0);
    rst = 0;
    vpct = 100;
    rpct = 100;
    fire_cyc.delete();
    hs_cyc.delete();
    d0 = done_cnt;
    do_start(3);
    wait_done(100, "basic");
    repeat (5) @(negedge clk);
    chk("basic_fires", K'(fire_cyc.size()), 3);
    chk("basic_outs", K'(hs_cyc.size()), 3);
    for (int i = 0; i < 3 && i < fire_cyc.size() && i < hs_cyc.size(); i++) begin
      chk("basic_fire_cycle", K'(fire_cyc[i]), K'(i + 1));
      chk("basic_o_valid_cycle", K'(hs_cyc[i]), K'(LAT + 2 + i));
    end
    chk("basic_done_once", K'(done_cnt - d0), 1);
    chk("basic_cid", K'(cid), 1);
    f0 = fires;
    h0 = hs_cnt;
    do_start(0);
    wait_done(10, "empty");
    repeat (3) @(negedge clk);
    chk("empty_done_within3", K'(done_cyc <= 3), 1);
    chk("empty_no_fire", K'(fires - f0), 0);
    chk("empty_no_output", K'(hs_cnt - h0), 0);
    rpct = 0;
    f0 = fires;
    h0 = hs_cnt;
    do_start(10);
    wait_fires(f0 + 4, 50);
    repeat (21) @(negedge clk);
    chk("bp_fires", K'(fires - f0), 4);
    chk("bp_g_ready", K'(bus.g_ready), 0);
`ifdef GC_SCHED_STATS_EN
    chk("bp_stall_cycles", K'(stall_cycles), 20);
`endif
    rpct = 100;
    wait_done(500, "bp");
    chk("bp_delivered", K'(hs_cnt - h0), 10);
`ifdef GC_SCHED_STATS_EN
    chk("bp_stall_total", K'(stall_cycles), K'(exp_stall));
`endif
    vpct = 50;
    rpct = 60;
    h0 = hs_cnt;
    do_start(1000);
    wait_done(40000, "random");
    chk("random_delivered", K'(hs_cnt - h0), 1000);
    chk("random_cid", K'(cid), 4);
    vpct = 100;
    rpct = 100;
    f0 = fires;
    do_start(20);
    wait_fires(f0 + 5, 50);
    #1;
    rst = 1;
    vpct = 0;
    bus.g_valid = 0;
    #1;
    chk("mid_rst_busy", K'(busy), 0);
    chk("mid_rst_g_ready", K'(bus.g_ready), 0);
    chk("mid_rst_o_valid", K'(bus.o_valid), 0);
    chk("mid_rst_cid", K'(cid), 0);
    chk("mid_rst_eng_gid", K'(eng_gid), 0);
    chk("mid_rst_eng_in1", eng_in1_label, 0);
    chk("mid_rst_o_addr", K'(bus.o_addr), 0);
    q.delete();
    exp_cid = '0;
    exp_gid = '0;
    rem_m = 0;
    h0 = hs_cnt;
    @(posedge clk);
    #1;
    rst = 0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_output", K'(hs_cnt - h0), 0);
    vpct = 100;
    do_start(4);
    wait_done(100, "post_rst");
    chk("post_rst_delivered", K'(hs_cnt - h0), 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
